// File: rtl/bridge_pkg.sv
// Shared encodings for the memory bridge and the control unit that consumes Op/Funct.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_IR,
        DST_MDR
    } dest_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts REQ cycles without acknowledge; expired marks the last permitted wait cycle.
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_bridge.sv
// Converts control-unit memory strobes into a req/ack bus transaction and holds IR/MDR.
module mem_bridge
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  I_or_D,
    input  logic                  IR_Write,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [ADDR_WIDTH-1:0] ALU_Out,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [5:0]            Op,
    output logic [5:0]            Funct,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Stall,
    output logic                  Align_Error,
    output logic                  Bus_Error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    state_t                state;
    state_t                state_next;
    dest_t                 dest;
    dest_t                 dest_sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  acc;
    logic                  aligned;
    logic                  accept;
    logic                  misalign;
    logic                  complete;
    logic                  timeout;
    logic                  expired;

    assign acc     = IR_Write | Mem_Read | Mem_Write;
    assign addr    = I_or_D ? ALU_Out : PC;
    assign aligned = (addr[1:0] == 2'b00);

    // Store wins over load, load over fetch; a store never writes back a register.
    assign dest_sel = Mem_Write ? DST_NONE : (Mem_Read ? DST_MDR : DST_IR);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        misalign   = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (acc && aligned) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end else if (acc) begin
                    misalign = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Instr       <= '0;
            Data        <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            dest        <= DST_NONE;
            Bus_Error   <= 1'b0;
            Align_Error <= 1'b0;
        end else begin
            Align_Error <= misalign;
            if (accept) begin
                mem_addr  <= addr;
                mem_we    <= Mem_Write;
                mem_wdata <= Write_Data;
                dest      <= dest_sel;
            end
            if (complete) begin
                case (dest)
                    DST_IR:  Instr <= mem_rdata;
                    DST_MDR: Data  <= mem_rdata;
                    default: ;
                endcase
            end
            if (timeout) begin
                Bus_Error <= 1'b1;
            end
        end
    end

    bus_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     ((state == REQ) && !mem_ack),
        .expired(expired)
    );

    assign mem_req = (state == REQ);
    assign Stall   = (state == REQ) || ((state == IDLE) && acc && aligned);
    assign Op      = Instr[OP_MSB:OP_LSB];
    assign Funct   = Instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed and random accesses against a transaction-level model.
module tb_mem_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        I_or_D, IR_Write, Mem_Read, Mem_Write;
    logic [31:0] PC, ALU_Out, Write_Data, mem_rdata;
    logic        mem_ack;
    logic [31:0] Instr, Data, mem_addr, mem_wdata;
    logic [5:0]  Op, Funct;
    logic        Stall, Align_Error, Bus_Error, mem_req, mem_we;

    int total = 0;
    int bad   = 0;

    // Architectural model: what IR, MDR and the sticky error should hold.
    logic [31:0] instr_exp, data_exp;
    logic        berr_exp;

    mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .I_or_D(I_or_D), .IR_Write(IR_Write),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .PC(PC), .ALU_Out(ALU_Out),
        .Write_Data(Write_Data), .Instr(Instr), .Op(Op), .Funct(Funct), .Data(Data),
        .Stall(Stall), .Align_Error(Align_Error), .Bus_Error(Bus_Error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic drop_strobes();
        IR_Write = 0; Mem_Read = 0; Mem_Write = 0;
    endtask

    // One access from presentation (cycle N) through its DONE cycle.
    task automatic do_access(input logic w, input logic r, input logic f, input logic iod,
                             input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] rd, input int waits);
        logic [31:0] addr;
        logic        aligned;
        int          req_cycles;
        addr    = iod ? alu : pc;
        aligned = (addr[1:0] == 2'b00);
        @(posedge clk); #1;
        Mem_Write = w; Mem_Read = r; IR_Write = f; I_or_D = iod;
        PC = pc; ALU_Out = alu; Write_Data = wd; mem_ack = 0;
        @(negedge clk);
        total++; if (Stall !== aligned) begin bad++; $display("FAIL stall_at_request got=%b want=%b", Stall, aligned); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL req_at_request got=%b want=0", mem_req); end
        if (!aligned) begin
            @(posedge clk); #1; drop_strobes();
            @(negedge clk);
            total++; if (Align_Error !== 1'b1) begin bad++; $display("FAIL align_pulse got=%b want=1", Align_Error); end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL align_no_req got=%b want=0", mem_req); end
            total++; if (Data !== data_exp) begin bad++; $display("FAIL align_data got=%h want=%h", Data, data_exp); end
            total++; if (Instr !== instr_exp) begin bad++; $display("FAIL align_instr got=%h want=%h", Instr, instr_exp); end
            @(posedge clk); #1;
            @(negedge clk);
            total++; if (Align_Error !== 1'b0) begin bad++; $display("FAIL align_one_cycle got=%b want=0", Align_Error); end
            return;
        end
        req_cycles = (waits < TO) ? waits + 1 : TO;
        for (int i = 0; i < req_cycles; i++) begin
            @(posedge clk); #1;
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? rd : $urandom;
            if (i == 1) drop_strobes();
            @(negedge clk);
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL req_held cyc=%0d got=%b want=1", i, mem_req); end
            total++; if (mem_addr !== addr) begin bad++; $display("FAIL addr cyc=%0d got=%h want=%h", i, mem_addr, addr); end
            total++; if (mem_we !== w) begin bad++; $display("FAIL we cyc=%0d got=%b want=%b", i, mem_we, w); end
            total++; if (mem_wdata !== wd) begin bad++; $display("FAIL wdata cyc=%0d got=%h want=%h", i, mem_wdata, wd); end
            total++; if (Stall !== 1'b1) begin bad++; $display("FAIL stall_in_req cyc=%0d got=%b want=1", i, Stall); end
        end
        @(posedge clk); #1;
        mem_ack = 0; drop_strobes();
        if (waits >= TO) berr_exp = 1'b1;
        else if (!w) begin
            if (r) data_exp = rd;
            else   instr_exp = rd;
        end
        @(negedge clk);
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL stall_done got=%b want=0", Stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL req_done got=%b want=0", mem_req); end
        total++; if (Instr !== instr_exp) begin bad++; $display("FAIL instr got=%h want=%h", Instr, instr_exp); end
        total++; if (Data !== data_exp) begin bad++; $display("FAIL data got=%h want=%h", Data, data_exp); end
        total++; if (Op !== instr_exp[31:26]) begin bad++; $display("FAIL op got=%h want=%h", Op, instr_exp[31:26]); end
        total++; if (Funct !== instr_exp[5:0]) begin bad++; $display("FAIL funct got=%h want=%h", Funct, instr_exp[5:0]); end
        total++; if (Bus_Error !== berr_exp) begin bad++; $display("FAIL bus_error got=%b want=%b", Bus_Error, berr_exp); end
    endtask

    task automatic test_reset();
        reset = 1; drop_strobes(); I_or_D = 0; PC = '0; ALU_Out = '0;
        Write_Data = '0; mem_rdata = '0; mem_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", Instr); end
        total++; if (Data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", Data); end
        total++; if ({Op, Funct} !== 12'h0) begin bad++; $display("FAIL rst_opfunct got=%h want=0", {Op, Funct}); end
        total++; if ({mem_req, mem_we, Bus_Error, Align_Error, Stall} !== 5'b0) begin
            bad++; $display("FAIL rst_flags got=%b want=00000", {mem_req, mem_we, Bus_Error, Align_Error, Stall}); end
        total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rst_bus got=%h want=0", {mem_addr, mem_wdata}); end
        @(posedge clk); #1; reset = 0;
        instr_exp = '0; data_exp = '0; berr_exp = 0;
    endtask

    task automatic test_fetch();
        do_access(0, 0, 1, 0, 32'h40, $urandom, $urandom, 32'h8C820004, 0);
        total++; if (Op !== 6'h23) begin bad++; $display("FAIL fetch_op got=%h want=23", Op); end
        total++; if (Funct !== 6'h04) begin bad++; $display("FAIL fetch_funct got=%h want=04", Funct); end
    endtask

    task automatic test_load();
        do_access(0, 1, 0, 1, 32'h44, 32'h100, $urandom, 32'hDEADBEEF, 3);
        total++; if (Data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", Data); end
        total++; if (Instr !== 32'h8C820004) begin bad++; $display("FAIL load_instr got=%h want=8c820004", Instr); end
    endtask

    task automatic test_store();
        do_access(1, 0, 0, 1, 32'h48, 32'h200, 32'h12345678, $urandom, 2);
    endtask

    task automatic test_misaligned();
        do_access(0, 1, 0, 1, 32'h4C, 32'h203, $urandom, $urandom, 0);
        do_access(0, 0, 1, 0, 32'h52, $urandom, $urandom, $urandom, 0);
    endtask

    task automatic test_priority();
        do_access(1, 1, 1, 1, 32'h60, 32'h300, 32'hA5A5A5A5, 32'h11111111, 1);
        do_access(0, 1, 1, 1, 32'h64, 32'h304, $urandom, 32'h22222222, 0);
        do_access(0, 1, 1, 0, 32'h68, 32'h30B, $urandom, 32'h33333333, 0);
    endtask

    task automatic test_back_to_back();
        do_access(0, 0, 1, 0, 32'h70, $urandom, $urandom, 32'h01234567, 0);
        do_access(0, 1, 0, 1, 32'h74, 32'h400, $urandom, 32'h89ABCDEF, 0);
        do_access(1, 0, 0, 1, 32'h78, 32'h404, 32'hFEEDFACE, $urandom, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  s;
            logic [31:0] pc, alu;
            s = 3'($urandom_range(1, 7));
            pc = $urandom; alu = $urandom;
            if ($urandom_range(3) != 0) begin pc[1:0] = 2'b00; alu[1:0] = 2'b00; end
            do_access(s[2], s[1], s[0], 1'($urandom_range(1)), pc, alu, $urandom, $urandom,
                      $urandom_range(0, 5));
        end
    endtask

    task automatic test_timeout();
        do_access(0, 0, 1, 0, 32'h80, $urandom, $urandom, $urandom, TO);
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL late_ack_req got=%b want=0", mem_req); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        total++; if (Instr !== instr_exp) begin bad++; $display("FAIL late_ack_instr got=%h want=%h", Instr, instr_exp); end
        total++; if (Data !== data_exp) begin bad++; $display("FAIL late_ack_data got=%h want=%h", Data, data_exp); end
        total++; if (Bus_Error !== 1'b1) begin bad++; $display("FAIL berr_sticky got=%b want=1", Bus_Error); end
        do_access(0, 0, 1, 0, 32'h84, $urandom, $urandom, 32'h0BADF00D, 1);
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1; IR_Write = 1; I_or_D = 0; PC = 32'h300; mem_ack = 0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req_started got=%b want=1", mem_req); end
        @(posedge clk); #1; reset = 1; drop_strobes();
        @(posedge clk); #1; reset = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        instr_exp = '0; data_exp = '0; berr_exp = 0;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%b want=0", mem_req); end
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL mid_rst_instr got=%h want=0", Instr); end
        total++; if (Data !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", Data); end
        total++; if (Bus_Error !== 1'b0) begin bad++; $display("FAIL mid_rst_berr got=%b want=0", Bus_Error); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%b want=0", Stall); end
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL stale_ack_instr got=%h want=0", Instr); end
        total++; if (Data !== 32'h0) begin bad++; $display("FAIL stale_ack_data got=%h want=0", Data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stale_ack_req got=%b want=0", mem_req); end
        do_access(0, 1, 0, 1, 32'h0, 32'h500, $urandom, 32'h76543210, 2);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_misaligned();
        test_priority();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits between the multicycle datapath/control unit and a unified instruction/data memory that has variable wait states.
- Turns the per-state memory strobes from the control unit (IR_Write, Mem_Read, Mem_Write) into a req/ack bus transaction.
- Holds the Instruction Register and Memory Data Register, and drives Op/Funct downstream to the control unit.
- Asserts Stall, which freezes the control FSM (no state advance, PC_En/Reg_Write/IR_Write effects held) until the access completes.

Parameters:
- DATA_WIDTH, 32, bus and register data width.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 16, REQ cycles without mem_ack before the bus error is raised (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- I_or_D  in  1  0: address = PC, 1: address = ALU_Out
- IR_Write  in  1  fetch access; read result loads IR
- Mem_Read  in  1  data read; read result loads MDR
- Mem_Write  in  1  data write of Write_Data
- PC  in  ADDR_WIDTH  fetch address
- ALU_Out  in  ADDR_WIDTH  data address
- Write_Data  in  DATA_WIDTH  store data (B register)
- Instr  out  DATA_WIDTH  Instruction Register
- Op  out  6  Instr[31:26]
- Funct  out  6  Instr[5:0]
- Data  out  DATA_WIDTH  Memory Data Register
- Stall  out  1  hold control FSM and datapath enables
- Align_Error  out  1  one-cycle pulse, misaligned request dropped
- Bus_Error  out  1  sticky timeout flag
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Clock and reset: the block has one clock, `clk`. Reset is the port `reset`, which is synchronous and active-high.
- Reset values: state=IDLE; Instr=0 (so Op=0, Funct=0); Data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; Bus_Error=0; Align_Error=0.
- Reset has priority over every other event. Reset mid-transaction drops mem_req the next cycle, with no completion, and returns to IDLE. A stale mem_ack seen in IDLE is ignored.
- Request decode: acc = IR_Write | Mem_Read | Mem_Write.
  - Priority when several strobes are high together: Mem_Write > Mem_Read > IR_Write. Only one access is performed.
  - Address: addr = I_or_D ? ALU_Out : PC.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If acc and addr[1:0]==0: latch mem_addr=addr, mem_we=Mem_Write, mem_wdata=Write_Data and the destination (IR/MDR/none). Set mem_req=1 next cycle, go to REQ.
  - If acc and addr[1:0]!=0: Align_Error=1 for the next cycle. No bus activity. Stay in IDLE. The access counts as complete.
- REQ:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - On mem_ack: a read loads mem_rdata into the latched destination; mem_req=0 next cycle; go to DONE.
  - The timeout counter clears on REQ entry and increments each REQ cycle without ack. At count==TIMEOUT-1 with no ack: Bus_Error=1 (sticky until reset), mem_req=0, destination unchanged, go to DONE.
- DONE: one cycle, then IDLE. Lets the control FSM advance exactly once per access.
- Stall (combinational from registered state and inputs): Stall = (IDLE & acc & aligned) | REQ. Stall=0 in DONE and on a misaligned request.
- Input stability: inputs are held by the stalled control unit. If acc drops during REQ, the bus transaction still completes; mem_req never drops without ack or timeout.
- Latency: request first seen in cycle N; earliest ack in N+1; IR/MDR updated at the N+1 edge; DONE in N+2; Stall low from N+2.
- Back-to-back: the earliest new request is accepted in the IDLE cycle after DONE.
- Op and Funct are pure slices of the registered Instr, with no extra delay.

Decomposition:
- Shared package (bridge_pkg):
  - state encoding IDLE/REQ/DONE
  - destination encoding DST_NONE/DST_IR/DST_MDR
  - OP_MSB/OP_LSB and FUNCT_MSB/FUNCT_LSB field constants, also used by the control unit
- Sub-module bus_timeout_counter:
  - inputs clk, reset, clr, en; output expired
  - width $clog2(TIMEOUT)

Test Plan:
- Fetch, 0 wait states: PC=0x00000040, IR_Write=1, mem_rdata=0x8C820004 with ack at N+1 -> mem_addr=0x40, mem_we=0; Instr=0x8C820004, Op=0x23, Funct=0x04 after the N+1 edge; Stall high N..N+1, low N+2.
- Load, 3 wait states: I_or_D=1, ALU_Out=0x100, Mem_Read=1, ack at N+4 with 0xDEADBEEF -> mem_req high N+1..N+4; Data=0xDEADBEEF; Instr unchanged; Stall low at N+5.
- Store: Mem_Write=1, ALU_Out=0x200, Write_Data=0x12345678 -> mem_we=1, mem_wdata=0x12345678 held until ack; IR and MDR unchanged.
- Misaligned: I_or_D=1, ALU_Out=0x203, Mem_Read=1 -> mem_req stays 0, Align_Error pulses one cycle, Stall=0, Data unchanged.
- Timeout: TIMEOUT=16, no ack -> Bus_Error=1 after 16 REQ cycles, mem_req drops, DONE cycle with Stall=0; a late ack in IDLE is ignored; Bus_Error stays 1 until reset.
- Reset mid-REQ: assert reset in the 2nd wait cycle -> next cycle mem_req=0, Instr=0, Data=0, Bus_Error=0, state IDLE; ack on the following cycle causes no register update.
